// File: rtl/chunked_add_sub_unit.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry rippled through a register.
// Define CHUNKED_ADD_SUB_OVERFLOW_EN to add a signed-overflow output.
module chunked_add_sub_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             add_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             complete,
    output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             cout
);

    localparam int NCHUNK = (WIDTH / CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] work_next;
    logic             carry_into_msb;
    logic             msb_overflow;

    always_comb begin
        a_chunk   = a_r[idx*CHUNK +: CHUNK];
        b_chunk   = b_r[idx*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk}
                  + {{CHUNK{1'b0}}, carry_r};
        work_next = work_r;
        work_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        // Recover the carry into the top bit from the sum bit and its operands.
        carry_into_msb = chunk_sum[CHUNK-1]
                       ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        msb_overflow   = carry_into_msb ^ chunk_sum[CHUNK];
    end

    assign busy     = (state == RUN);
    assign complete = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= add_sub ? ~b : b;
                        carry_r <= add_sub;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    work_r  <= work_next;
                    carry_r <= chunk_sum[CHUNK];
                    idx     <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        sum   <= work_next;
                        cout  <= chunk_sum[CHUNK];
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            overflow <= msb_overflow;
        end
    end
`else
    logic unused_ov;
    assign unused_ov = msb_overflow;
`endif

endmodule

// File: tb/tb_chunked_add_sub_unit.sv
// Directed testbench for chunked_add_sub_unit (WIDTH=64, CHUNK=8).
// Overflow checks are compiled in with CHUNKED_ADD_SUB_OVERFLOW_EN.
module tb_chunked_add_sub_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        add_sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        complete;
    logic [63:0] sum;
    logic        cout;
`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
    logic        overflow;
`endif

    int total = 0;
    int bad   = 0;

    chunked_add_sub_unit #(.WIDTH(64), .CHUNK(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .add_sub  (add_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .complete (complete),
        .sum      (sum),
`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
        .overflow (overflow),
`endif
        .cout     (cout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op; lat = edges from accept to complete, busy_ok = busy held.
    task automatic do_op(input logic [63:0] x, input logic [63:0] y,
                         input logic op, output int lat,
                         output logic busy_ok);
        @(negedge clock);
        a = x; b = y; add_sub = op; start = 1'b1;
        @(negedge clock);
        start = 1'b0; a = ~x; b = ~y; add_sub = ~op;
        lat = 0;
        busy_ok = 1'b1;
        while (!complete && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
    endtask

    int   lat;
    logic bok;
    int   cnt;
    logic [63:0] bx [4];
    logic [63:0] by [4];
    logic        bop [4];
    logic [63:0] bs [4];
    logic        bc [4];

    initial begin
        reset = 1'b1; start = 1'b0; add_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_complete", {63'd0, complete}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        reset = 1'b0;

        do_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, bok);
        check("wrap_lat", 64'(lat), 64'd8);
        check("wrap_busy", {63'd0, bok}, 64'd1);
        check("wrap_busy_done", {63'd0, busy}, 64'd0);
        check("wrap_sum", sum, 64'd0);
        check("wrap_cout", {63'd0, cout}, 64'd1);
        repeat (3) @(negedge clock);
        check("wrap_hold_sum", sum, 64'd0);
        check("wrap_hold_cpl", {63'd0, complete}, 64'd1);

        do_op(64'd5, 64'd7, 1'b1, lat, bok);
        check("sub57_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub57_cout", {63'd0, cout}, 64'd0);
`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
        check("sub57_ovf", {63'd0, overflow}, 64'd0);
`endif
        do_op(64'd7, 64'd5, 1'b1, lat, bok);
        check("sub75_sum", sum, 64'd2);
        check("sub75_cout", {63'd0, cout}, 64'd1);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
              lat, bok);
        check("subeq_sum", sum, 64'd0);
        check("subeq_cout", {63'd0, cout}, 64'd1);

        // Start while busy: second request on edges 3..5 must be ignored.
        @(negedge clock);
        a = 64'h10; b = 64'h20; add_sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        a = 64'hFF; b = 64'hFF; start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("busy_ign_cpl", {63'd0, complete}, 64'd1);
        check("busy_ign_sum", sum, 64'h30);
        repeat (3) @(negedge clock);
        check("busy_ign_hold", sum, 64'h30);

        // Back-to-back with start held high.
        bx[0] = 64'd1;                  by[0] = 64'd2;
        bop[0] = 1'b0; bs[0] = 64'd3;   bc[0] = 1'b0;
        bx[1] = 64'hFFFF_FFFF_FFFF_FFFF; by[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        bop[1] = 1'b0; bs[1] = 64'hFFFF_FFFF_FFFF_FFFE; bc[1] = 1'b1;
        bx[2] = 64'd0;                  by[2] = 64'd1;
        bop[2] = 1'b1; bs[2] = 64'hFFFF_FFFF_FFFF_FFFF; bc[2] = 1'b0;
        bx[3] = 64'h00FF_00FF_00FF_00FF; by[3] = 64'h0101_0101_0101_0101;
        bop[3] = 1'b0; bs[3] = 64'h0200_0200_0200_0200; bc[3] = 1'b0;
        @(negedge clock);
        a = bx[0]; b = by[0]; add_sub = bop[0]; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            @(negedge clock);
            while (!complete && cnt < 20) begin
                cnt++;
                @(negedge clock);
            end
            check($sformatf("b2b_gap%0d", i), 64'(cnt), 64'd8);
            check($sformatf("b2b_sum%0d", i), sum, bs[i]);
            check($sformatf("b2b_cout%0d", i), {63'd0, cout},
                  {63'd0, bc[i]});
            if (i < 3) begin
                a = bx[i+1]; b = by[i+1]; add_sub = bop[i+1];
            end else begin
                start = 1'b0;
            end
        end

        // Reset in the middle of an operation.
        @(negedge clock);
        a = 64'hDEAD_BEEF; b = 64'd1; add_sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_cpl", {63'd0, complete}, 64'd0);
        check("mid_rst_sum", sum, 64'd0);
        check("mid_rst_cout", {63'd0, cout}, 64'd0);
        do_op(64'd3, 64'd4, 1'b0, lat, bok);
        check("post_rst_lat", 64'(lat), 64'd8);
        check("post_rst_sum", sum, 64'd7);

`ifdef CHUNKED_ADD_SUB_OVERFLOW_EN
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, bok);
        check("ovf_add_sum", sum, 64'h8000_0000_0000_0000);
        check("ovf_add_ovf", {63'd0, overflow}, 64'd1);
        check("ovf_add_cout", {63'd0, cout}, 64'd0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, lat, bok);
        check("ovf_sub_sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ovf_sub_ovf", {63'd0, overflow}, 64'd1);
        do_op(64'd5, 64'd7, 1'b1, lat, bok);
        check("ovf_57", {63'd0, overflow}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_add_sub_unit.md
Name: chunked_add_sub_unit

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register.
- Successor to the fixed 8-bit registered add/sub block: generalised width, proper subtract carry-in, a start/busy/complete handshake and held results.
- Sits beside the carry-select and conditional-sum adders as the area-lean, low-throughput reference datapath for 64-bit comparisons.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per RUN cycle; NCHUNK = WIDTH/CHUNK, minimum 1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge only when busy=0.
- add_sub  input  1  mode, captured with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high while an operation is in progress.
- complete  output  1  high while the held result is valid.
- sum  output  WIDTH  result of the last completed operation.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.

Behaviour:
- Reset, checked first and overriding all else:
  - state=IDLE, busy=0, complete=0, sum=0, cout=0.
  - Internal operand, working-sum, carry and chunk-index registers cleared.
  - Applies mid-operation too: the in-flight operation is abandoned and no partial result is shown.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 on an edge:
  - Capture a into A_r.
  - Capture b into B_r, or ~b into B_r when add_sub=1.
  - carry_r = add_sub, idx = 0.
  - Next state RUN: busy=1, complete=0.
  - sum and cout keep their old values until the new result lands.
- IDLE or DONE, start=0: hold state and all outputs.
- RUN, each edge:
  - {c, s} = A_r[idx*CHUNK +: CHUNK] + B_r[idx*CHUNK +: CHUNK] + carry_r. Chunk add is CHUNK+1 bits wide.
  - Write s into the working register at the same slice; carry_r = c; idx = idx+1.
  - On the edge processing idx = NCHUNK-1:
    - sum = full working value including the last chunk; cout = c.
    - Next state DONE: busy=0, complete=1.
- Latency: start accepted on edge k gives complete=1 and a valid sum after edge k+NCHUNK.
  - Throughput is one operation per NCHUNK+1 cycles when start is held high; no IDLE cycle is needed between operations.
- start while busy=1: ignored. Operands are not re-sampled and the operation is not restarted.
- Inputs a, b and add_sub may change freely after the capture edge.
- NCHUNK=1: RUN lasts a single cycle.
- Arithmetic is modulo 2^WIDTH; cout is the only extra-width information.
- Subtraction: result is a + ~b + 1 in two's complement.
  - a-b with a<b wraps, and cout=0.
  - a==b gives sum=0, cout=1.

Optional Feature:
- Macro: CHUNKED_ADD_SUB_OVERFLOW_EN.
- Defined:
  - Extra output port overflow (1 bit), reset 0, updated on the same edge as sum.
  - overflow = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow for the selected mode.
  - Requires capturing the carry into bit WIDTH-1 during the last chunk.
- Not defined: no overflow port or logic. All other behaviour is identical.

Test Plan:
- Test parameters: WIDTH=64, CHUNK=8.
- Add wrap: a=0x0000_0000_0000_0001, b=0xFFFF_FFFF_FFFF_FFFF, add_sub=0, start pulse on edge 0 -> busy=1 on edges 1-7; complete=1 after edge 8; sum=0, cout=1. Outputs are stable until the next start.
- Subtract with borrow: a=5, b=7, add_sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 -> sum=2, cout=1. Then a=b=0x1234_5678_9ABC_DEF0 -> sum=0, cout=1.
- Start while busy: start 0x10+0x20, then raise start with a=0xFF, b=0xFF on edges 3-5 -> result is still 0x30 at edge 8; the later request is not executed.
- Back-to-back: start held high with a new operand pair applied each time complete=1 -> a new operation is accepted on every DONE edge; complete drops for exactly 8 cycles between results; each sum matches the reference model.
- Reset mid-op: start 0xDEAD_BEEF+1, assert reset on edge 4 -> busy=0, complete=0, sum=0, cout=0 after that edge. A following start 3+4 yields sum=7 after 8 cycles.
- Overflow (macro defined):
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
  - a=0x8000_0000_0000_0000, b=1, sub -> overflow=1.
  - 5-7 -> overflow=0.
